// File: rtl/axi4_rd_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : axi4_rd_cmd_issuer
// Purpose  : Accepts read requests (start address, beat count) over a
//            valid/ready handshake, queues them in a show-ahead command FIFO
//            and issues one AXI4 INCR read burst per request on the AR
//            channel. Also watches R-channel handshakes and pulses last_drop
//            one cycle after the final beat of each burst.
// Ports    : axi_aclk / axi_aresetn  - clock, synchronous active-low reset
//            source_addr, size       - request start address and beat count
//            valid / ready           - request handshake (ready = FIFO not full)
//            axi_ar*                 - AXI4 read address channel (master side)
//            axi_rvalid/rready/rlast - R channel, monitored only
//            last_drop               - registered end-of-burst pulse
//            fifo_count              - command FIFO occupancy
// Option   : AXI4_RD_OUTSTANDING_LIMIT_EN - when defined, caps the number of
//            bursts in flight at MAX_OUTSTANDING.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_rd_cmd_issuer #(
  parameter int DEPTH           = 4,
  parameter int DSIZE           = 64,
  parameter int ASIZE           = 32,
  parameter int LSIZE           = 8,
  parameter int IDSIZE          = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [31:0]              source_addr,
  input  logic [31:0]              size,
  input  logic                     valid,
  output logic                     ready,
  output logic [IDSIZE-1:0]        axi_arid,
  output logic [ASIZE-1:0]         axi_araddr,
  output logic [LSIZE-1:0]         axi_arlen,
  output logic [2:0]               axi_arsize,
  output logic [1:0]               axi_arburst,
  output logic                     axi_arvalid,
  input  logic                     axi_arready,
  input  logic                     axi_rvalid,
  input  logic                     axi_rready,
  input  logic                     axi_rlast,
  output logic                     last_drop,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0]      ARSIZE   = 3'($clog2(DSIZE/8));
  localparam logic [LSIZE:0]  ONE_N    = (LSIZE+1)'(1);

  // Command storage: only the address bits and the effective length bits
  // are ever used, so only those are kept.
  logic [ASIZE-1:0] mem_addr [DEPTH];
  logic [LSIZE:0]   mem_len  [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             load;
  logic             drop;
  logic             limit_ok;
  logic [ASIZE-1:0] head_addr;
  logic [LSIZE:0]   head_n;

  // Upper size bits beyond the effective length are intentionally ignored.
  logic unused_size;
  assign unused_size = ^size[31:LSIZE+1];

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign ready     = !full;
  assign push      = valid && !full;
  assign head_addr = mem_addr[rptr];
  assign head_n    = mem_len[rptr];

  assign axi_arid    = '0;
  assign axi_arsize  = ARSIZE;
  assign axi_arburst = 2'b01;
  assign fifo_count  = count;

  // A zero-length head is discarded without an AR; a non-zero head moves
  // into the AR register once that register is free or being handed off.
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    if (!empty) begin
      if (head_n == '0) begin
        drop = 1'b1;
      end else if ((!axi_arvalid || axi_arready) && limit_ok) begin
        load = 1'b1;
      end
    end
  end

  assign pop = load || drop;

  // Command FIFO
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_len[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_addr[wptr] <= source_addr[ASIZE-1:0];
        mem_len[wptr]  <= size[LSIZE:0];
        wptr           <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // AR register: fields only change on a load, so they hold steady while
  // the slave back-pressures.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
    end else begin
      if (load) begin
        axi_arvalid <= 1'b1;
        axi_araddr  <= head_addr;
        axi_arlen   <= LSIZE'(head_n - ONE_N);
      end else if (axi_arready) begin
        axi_arvalid <= 1'b0;
      end
    end
  end

  // End-of-burst pulse, one cycle after the last-beat handshake.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      last_drop <= 1'b0;
    end else begin
      last_drop <= axi_rvalid && axi_rready && axi_rlast;
    end
  end

`ifdef AXI4_RD_OUTSTANDING_LIMIT_EN
  localparam int OW = $clog2(MAX_OUTSTANDING + 1) + 1;

  logic [OW-1:0] outstanding;
  logic          ar_hs;
  logic          r_done;

  assign ar_hs  = axi_arvalid && axi_arready;
  assign r_done = axi_rvalid && axi_rready && axi_rlast && (outstanding != '0);

  // The AR currently held in the register is already committed, so it is
  // counted together with the bursts in flight; otherwise a load in the
  // same cycle as a handshake could overshoot the cap by one.
  assign limit_ok = (int'(outstanding) + int'(axi_arvalid)) < MAX_OUTSTANDING;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, r_done})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
`else
  logic unused_max;
  assign unused_max = (MAX_OUTSTANDING != 0);
  assign limit_ok   = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_rd_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_rd_cmd_issuer
// Purpose  : Self-checking bench for axi4_rd_cmd_issuer. A transaction-level
//            model keeps the queue of bursts expected on AR (in request
//            order, zero-length requests removed) and the expected last_drop
//            value; directed steps cover the listed scenarios, followed by a
//            randomized run and a drain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_rd_cmd_issuer;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] source_addr = '0;
  logic [31:0] size = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready = 1'b0;
  logic        rlast = 1'b0;
  logic        last_drop;
  logic [2:0]  fifo_count;

  axi4_rd_cmd_issuer #(
    .DEPTH(4), .DSIZE(64), .ASIZE(32), .LSIZE(8), .IDSIZE(4), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(aresetn),
    .source_addr(source_addr), .size(size), .valid(valid), .ready(ready),
    .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
    .axi_arburst(arburst), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rlast(rlast),
    .last_drop(last_drop), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ar_hs  = 0;
  int  outst  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: account for handshakes seen before the edge, then step past
  // the edge and compare the registered end-of-burst pulse.
  task automatic tick();
    bit         rl;
    logic [8:0] n;
    rl = 1'b0;
    if (aresetn) begin
      rl = rvalid && rready && rlast;
      if (arvalid) begin
        if (exp_q.size() == 0) begin
          chk("ar_spurious", 64'(arvalid), 64'd0);
        end else begin
          chk("araddr", 64'(araddr), 64'(exp_q[0].addr));
          chk("arlen", 64'(arlen), 64'(exp_q[0].len));
          chk("arsize", 64'(arsize), 64'd3);
          chk("arburst", 64'(arburst), 64'd1);
          chk("arid", 64'(arid), 64'd0);
          if (arready) begin
`ifdef AXI4_RD_OUTSTANDING_LIMIT_EN
            chk("outstanding_cap", 64'(outst < MAXO), 64'd1);
`endif
            void'(exp_q.pop_front());
            ar_hs++;
          end
        end
      end
      if (rl && outst > 0) outst--;
      if (arvalid && arready) outst++;
      if (valid && ready) begin
        n = size[8:0];
        if (n != 9'd0) exp_q.push_back('{source_addr, 8'(n - 9'd1)});
      end
    end else begin
      exp_q.delete();
      outst = 0;
    end
    @(posedge clk);
    #1;
    chk("last_drop", 64'(last_drop), 64'(rl));
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    valid   = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] s);
    bit hs;
    bit done;
    done        = 1'b0;
    valid       = 1'b1;
    source_addr = a;
    size        = s;
    for (int i = 0; i < 60 && !done; i++) begin
      hs = ready;
      tick();
      if (hs) done = 1'b1;
    end
    valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    valid   = 1'b0;
    arready = 1'b1;
    rvalid  = 1'b1;
    rready  = 1'b1;
    rlast   = 1'b1;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || arvalid || fifo_count != 0); i++) tick();
    rvalid = 1'b0;
    rready = 1'b0;
    rlast  = 1'b0;
    tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_fifo", 64'(fifo_count), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0;
    int cnt;

    // Reset then idle
    do_reset();
    tick();
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_last_drop", 64'(last_drop), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);

    // Single request, one-cycle latency, single-cycle arvalid
    arready = 1'b1;
    send(32'h1000, 32'd16);
    chk("lat_arvalid_k", 64'(arvalid), 64'd0);
    chk("lat_count_k", 64'(fifo_count), 64'd1);
    tick();
    chk("lat_arvalid_k1", 64'(arvalid), 64'd1);
    chk("lat_araddr", 64'(araddr), 64'h1000);
    chk("lat_arlen", 64'(arlen), 64'd15);
    chk("lat_arsize", 64'(arsize), 64'd3);
    chk("lat_arburst", 64'(arburst), 64'd1);
    chk("lat_arid", 64'(arid), 64'd0);
    tick();
    chk("single_arvalid", 64'(arvalid), 64'd0);
    chk("single_count", 64'(fifo_count), 64'd0);

    // Fill with back-pressure, then release: 5 ARs without gaps
    arready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h2000 + 32'(i * 64), 32'(i + 1));
    chk("full_ready", 64'(ready), 64'd0);
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_arvalid", 64'(arvalid), 64'd1);
    arready = 1'b1;
    cnt = 0;
    while (arvalid && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("no_gap_burst_count", 64'(cnt), 64'd5);
    chk("after_ready", 64'(ready), 64'd1);
    chk("after_count", 64'(fifo_count), 64'd0);

    // Zero-length entries are dropped, 256 beats gives arlen=255
    h0 = ar_hs;
    send(32'h3000, 32'd0);
    send(32'h3100, 32'd512);
    send(32'h3200, 32'd256);
    drain();
    chk("zero_len_ar_count", 64'(ar_hs - h0), 64'd1);

    // R-channel monitoring
    arready = 1'b1;
    rvalid  = 1'b1;
    rready  = 1'b1;
    rlast   = 1'b0;
    repeat (3) tick();
    rlast = 1'b1;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("rlast_pulse", 64'(last_drop), 64'd1);
    tick();
    chk("rlast_pulse_end", 64'(last_drop), 64'd0);
    rvalid = 1'b1;
    rlast  = 1'b1;
    rready = 1'b0;
    tick();
    chk("rlast_no_ready", 64'(last_drop), 64'd0);
    rvalid = 1'b0;
    rlast  = 1'b0;

    // Reset in the middle of a pending AR
    arready = 1'b0;
    send(32'h5000, 32'd8);
    send(32'h5100, 32'd8);
    tick();
    chk("mid_arvalid", 64'(arvalid), 64'd1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    tick();
    chk("mid_rst_idle", 64'(arvalid), 64'd0);

`ifdef AXI4_RD_OUTSTANDING_LIMIT_EN
    // Cap of two bursts in flight
    do_reset();
    arready = 1'b1;
    h0 = ar_hs;
    for (int i = 0; i < 3; i++) send(32'h6000 + 32'(i * 256), 32'd4);
    repeat (8) tick();
    chk("limit_two_ars", 64'(ar_hs - h0), 64'd2);
    rvalid = 1'b1;
    rready = 1'b1;
    rlast  = 1'b1;
    tick();
    rvalid = 1'b0;
    rready = 1'b0;
    rlast  = 1'b0;
    repeat (4) tick();
    chk("limit_third_ar", 64'(ar_hs - h0), 64'd3);
    drain();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      valid       = ($urandom % 2) == 0;
      source_addr = $urandom;
      case ($urandom % 4)
        0:       size = 32'd0;
        1:       size = 32'd512;
        2:       size = $urandom_range(1, 300);
        default: size = $urandom_range(1, 16);
      endcase
      arready = ($urandom % 3) != 0;
      rvalid  = ($urandom % 2) == 0;
      rready  = ($urandom % 2) == 0;
      rlast   = ($urandom % 4) == 0;
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
